alu_share_ctrl: RTL and testbench

Two-requester scheduler that time-shares the single 32-bit ALU between requesters, e.g. the execute stage and a branch-compare/address unit. Each requester has a valid/ready request channel (A, B, Op) and a valid/ready response channel (Out plus Z/N/C/V). The block arbitrates round-robin, registers operands, drives the ALU and captures its result. It owns the ALU input pins exclusively.

---
 rtl/alu_share_ctrl.sv | 177 +++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
//
// Time-shares one 32-bit ALU between two requesters. Each requester has a
// valid/ready request channel (A, B, Op) and a valid/ready response channel
// (Out plus {Z,N,C,V}). Requests are arbitrated round-robin, the operands are
// registered, the ALU is driven for one cycle, and its result is captured and
// held until the granted requester takes it.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   reqN_valid / reqN_ready    request handshake (ready is combinational)
//   reqN_A, reqN_B, reqN_Op    request operands and opcode
//   rspN_valid / rspN_ready    response handshake
//   rspN_Out, rspN_flags       result and {Z,N,C,V}
//   alu_A, alu_B, alu_Op       ALU inputs, owned exclusively by this block
//   alu_Out, alu_Z/N/C/V       ALU outputs
//   busy                       high whenever the scheduler is not idle
// -----------------------------------------------------------------------------
module alu_share_ctrl #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_A,
    input  logic [W-1:0] req0_B,
    input  logic [3:0]   req0_Op,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_A,
    input  logic [W-1:0] req1_B,
    input  logic [3:0]   req1_Op,

    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [W-1:0] rsp0_Out,
    output logic [3:0]   rsp0_flags,

    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp1_Out,
    output logic [3:0]   rsp1_flags,

    output logic [W-1:0] alu_A,
    output logic [W-1:0] alu_B,
    output logic [3:0]   alu_Op,
    input  logic [W-1:0] alu_Out,
    input  logic         alu_Z,
    input  logic         alu_N,
    input  logic         alu_C,
    input  logic         alu_V,

    output logic         busy
);

    // Opcode that makes the ALU produce zero; parked on the ALU when idle.
    localparam logic [3:0] OP_ZERO = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           prio_q,  prio_d;   // requester favoured on a tie
    logic           g_q,     g_d;      // requester owning the current transaction
    logic [W-1:0]   a_q,     a_d;
    logic [W-1:0]   b_q,     b_d;
    logic [3:0]     op_q,    op_d;
    logic [W-1:0]   out_q,   out_d;
    logic [3:0]     flags_q, flags_d;

    logic           grant0, grant1;
    logic           rsp_take;

    // Only SUB (3) and the two compares (8, 9) update the ALU flags; for any
    // other op the ALU flag pins carry stale values and must not be reported.
    function automatic logic op_sets_flags(input logic [3:0] op);
        return (op == 4'd3) || (op == 4'd8) || (op == 4'd9);
    endfunction

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        g_d      = g_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        out_d    = out_q;
        flags_d  = flags_q;
        grant0   = 1'b0;
        grant1   = 1'b0;
        rsp_take = 1'b0;

        case (state_q)
            IDLE: begin
                // Ready is combinational, so it must be held low during reset.
                if (!reset) begin
                    if (req0_valid && (!req1_valid || !prio_q)) begin
                        grant0 = 1'b1;
                    end else if (req1_valid) begin
                        grant1 = 1'b1;
                    end
                end
                if (grant0 || grant1) begin
                    a_d     = grant1 ? req1_A  : req0_A;
                    b_d     = grant1 ? req1_B  : req0_B;
                    op_d    = grant1 ? req1_Op : req0_Op;
                    g_d     = grant1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                out_d   = alu_Out;
                flags_d = op_sets_flags(op_q) ? {alu_Z, alu_N, alu_C, alu_V} : 4'b0000;
                state_d = RESP;
            end
            RESP: begin
                rsp_take = g_q ? rsp1_ready : rsp0_ready;
                if (rsp_take) begin
                    prio_d  = ~g_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and result state; result registers are cleared so that the
    // response outputs read zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            out_q   <= '0;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    // Operand registers and grant id are only observed in EXEC/RESP, which
    // reset leaves, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
        g_q  <= g_d;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign rsp0_valid = (state_q == RESP) && !g_q;
    assign rsp1_valid = (state_q == RESP) &&  g_q;
    assign rsp0_Out   = out_q;
    assign rsp1_Out   = out_q;
    assign rsp0_flags = flags_q;
    assign rsp1_flags = flags_q;

    assign alu_A  = (state_q == EXEC) ? a_q  : '0;
    assign alu_B  = (state_q == EXEC) ? b_q  : '0;
    assign alu_Op = (state_q == EXEC) ? op_q : OP_ZERO;

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_A, req0_B, req1_A, req1_B;
    logic [3:0]   req0_Op, req1_Op;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready, rsp1_ready;
    logic [W-1:0] rsp0_Out, rsp1_Out;
    logic [3:0]   rsp0_flags, rsp1_flags;
    logic [W-1:0] alu_A, alu_B, alu_Out;
    logic [3:0]   alu_Op;
    logic         alu_Z, alu_N, alu_C, alu_V;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.W(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_A(req0_A), .req0_B(req0_B), .req0_Op(req0_Op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_A(req1_A), .req1_B(req1_B), .req1_Op(req1_Op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_Out(rsp0_Out), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_Out(rsp1_Out), .rsp1_flags(rsp1_flags),
        .alu_A(alu_A), .alu_B(alu_B), .alu_Op(alu_Op),
        .alu_Out(alu_Out),
        .alu_Z(alu_Z), .alu_N(alu_N), .alu_C(alu_C), .alu_V(alu_V),
        .busy(busy)
    );

    // ALU stand-in. Flag pins always show A-B so that ops which must have
    // their flags masked present non-zero flags to the block.
    logic [W:0] diff;
    always_comb begin
        diff = {1'b0, alu_A} - {1'b0, alu_B};
        case (alu_Op)
            4'd0:    alu_Out = alu_A & alu_B;
            4'd1:    alu_Out = alu_A | alu_B;
            4'd2:    alu_Out = alu_A + alu_B;
            4'd3:    alu_Out = diff[W-1:0];
            4'd4:    alu_Out = alu_A ^ alu_B;
            4'd8:    alu_Out = {{(W-1){1'b0}}, ($signed(alu_A) < $signed(alu_B))};
            4'd9:    alu_Out = {{(W-1){1'b0}}, (alu_A < alu_B)};
            default: alu_Out = '0;
        endcase
        alu_Z = (diff[W-1:0] == '0);
        alu_N = diff[W-1];
        alu_C = ~diff[W];
        alu_V = (alu_A[W-1] != alu_B[W-1]) && (diff[W-1] != alu_A[W-1]);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_A = '0; req0_B = '0; req0_Op = 4'd0;
        req1_A = '0; req1_B = '0; req1_Op = 4'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready);
        end
        checks++;
        if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_valid_busy got=%b exp=000", {rsp0_valid, rsp1_valid, busy});
        end
        checks++;
        if (rsp0_Out !== '0 || rsp1_Out !== '0 || rsp0_flags !== 4'h0 || rsp1_flags !== 4'h0) begin
            failures++;
            $display("FAIL reset_rsp_data got=%h/%h %h/%h exp=0", rsp0_Out, rsp1_Out, rsp0_flags, rsp1_flags);
        end
        checks++;
        if (alu_A !== '0 || alu_B !== '0 || alu_Op !== 4'hD) begin
            failures++;
            $display("FAIL reset_alu got=%h %h %h exp=0 0 d", alu_A, alu_B, alu_Op);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_add;
        req0_valid = 1'b1; req0_A = 32'd5; req0_B = 32'd7; req0_Op = 4'd2;
        rsp0_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL add_accept got=%b%b exp=10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        #1;
        checks++;
        if (alu_A !== 32'd5 || alu_B !== 32'd7 || alu_Op !== 4'd2 || busy !== 1'b1 || rsp0_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_exec got=%h %h %h busy=%b v=%b exp=5 7 2 1 0", alu_A, alu_B, alu_Op, busy, rsp0_valid);
        end
        tick();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_Out !== 32'd12 || rsp0_flags !== 4'b0000) begin
            failures++;
            $display("FAIL add_resp got=v%b%b out=%h fl=%b exp=v10 out=c fl=0000", rsp0_valid, rsp1_valid, rsp0_Out, rsp0_flags);
        end
        checks++;
        if (alu_A !== '0 || alu_Op !== 4'hD) begin
            failures++;
            $display("FAIL add_alu_park got=%h %h exp=0 d", alu_A, alu_Op);
        end
        tick();
        checks++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL add_done got=v%b busy=%b exp=v0 busy=0", rsp0_valid, busy);
        end
        rsp0_ready = 1'b0;
    endtask

    task automatic test_sub_flags;
        req1_valid = 1'b1; req1_A = 32'd3; req1_B = 32'd3; req1_Op = 4'd3;
        rsp1_ready = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL sub_accept got=%b%b exp=01", req0_ready, req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        tick();
        checks++;
        if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_Out !== 32'd0 || rsp1_flags !== 4'b1010) begin
            failures++;
            $display("FAIL sub_resp got=v%b%b out=%h fl=%b exp=v01 out=0 fl=1010", rsp0_valid, rsp1_valid, rsp1_Out, rsp1_flags);
        end
        tick();
        rsp1_ready = 1'b0;
    endtask

    task automatic test_signed_cmp;
        req0_valid = 1'b1; req0_A = 32'h8000_0000; req0_B = 32'd1; req0_Op = 4'd8;
        rsp0_ready = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_Out !== 32'd1 || rsp0_flags !== 4'b0011) begin
            failures++;
            $display("FAIL slt_resp got=v%b out=%h fl=%b exp=v1 out=1 fl=0011", rsp0_valid, rsp0_Out, rsp0_flags);
        end
        tick();
        rsp0_ready = 1'b0;
    endtask

    task automatic test_flag_mask;
        rsp0_ready = 1'b1;
        // SUB 5-7 reports flags
        req0_valid = 1'b1; req0_A = 32'd5; req0_B = 32'd7; req0_Op = 4'd3;
        tick();
        req0_valid = 1'b0;
        tick();
        checks++;
        if (rsp0_Out !== 32'hFFFF_FFFE || rsp0_flags !== 4'b0100) begin
            failures++;
            $display("FAIL mask_sub got=out=%h fl=%b exp=out=fffffffe fl=0100", rsp0_Out, rsp0_flags);
        end
        tick();
        // ADD 1+1: ALU pins show Z=1,C=1 but must be masked
        req0_valid = 1'b1; req0_A = 32'd1; req0_B = 32'd1; req0_Op = 4'd2;
        tick();
        req0_valid = 1'b0;
        tick();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_Out !== 32'd2 || rsp0_flags !== 4'b0000) begin
            failures++;
            $display("FAIL mask_add got=v%b out=%h fl=%b exp=v1 out=2 fl=0000", rsp0_valid, rsp0_Out, rsp0_flags);
        end
        tick();
        // Op 13 accepted, returns zero with no flags
        req0_valid = 1'b1; req0_A = 32'd5; req0_B = 32'd5; req0_Op = 4'd13;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL op13_accept got=%b exp=1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        tick();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_Out !== 32'd0 || rsp0_flags !== 4'b0000) begin
            failures++;
            $display("FAIL op13_resp got=v%b out=%h fl=%b exp=v1 out=0 fl=0000", rsp0_valid, rsp0_Out, rsp0_flags);
        end
        tick();
        rsp0_ready = 1'b0;
    endtask

    task automatic test_arbitration;
        idle_inputs();
        apply_reset();
        req0_valid = 1'b1; req0_A = 32'd10; req0_B = 32'd1; req0_Op = 4'd2;
        req1_valid = 1'b1; req1_A = 32'd20; req1_B = 32'd2; req1_Op = 4'd3;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            int ph;
            int side;
            #1;
            ph   = c % 3;
            side = (c / 3) % 2;
            checks++;
            if (req0_ready !== (ph == 0 && side == 0) || req1_ready !== (ph == 0 && side == 1)) begin
                failures++;
                $display("FAIL arb_ready cyc=%0d got=%b%b", c, req0_ready, req1_ready);
            end
            checks++;
            if (rsp0_valid !== (ph == 2 && side == 0) || rsp1_valid !== (ph == 2 && side == 1)) begin
                failures++;
                $display("FAIL arb_rsp_valid cyc=%0d got=%b%b", c, rsp0_valid, rsp1_valid);
            end
            if (ph == 2 && side == 0) begin
                checks++;
                if (rsp0_Out !== 32'd11 || rsp0_flags !== 4'b0000) begin
                    failures++;
                    $display("FAIL arb_rsp0 cyc=%0d got=%h %b exp=b 0000", c, rsp0_Out, rsp0_flags);
                end
            end
            if (ph == 2 && side == 1) begin
                checks++;
                if (rsp1_Out !== 32'd18 || rsp1_flags !== 4'b0010) begin
                    failures++;
                    $display("FAIL arb_rsp1 cyc=%0d got=%h %b exp=12 0010", c, rsp1_Out, rsp1_flags);
                end
            end
            @(posedge clk);
        end
        #1;
        idle_inputs();
        // last grant was req1 and completed; next state accepts nothing
        tick();
    endtask

    task automatic test_backpressure;
        idle_inputs();
        req0_valid = 1'b1; req0_A = 32'd9; req0_B = 32'd4; req0_Op = 4'd2;
        req1_valid = 1'b1; req1_A = 32'd1; req1_B = 32'd1; req1_Op = 4'd2;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_accept got=%b%b exp=10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp0_valid !== 1'b1 || rsp0_Out !== 32'd13 || req1_ready !== 1'b0 || rsp1_valid !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold i=%0d got=v%b out=%h r1rdy=%b v1=%b exp=v1 out=d 0 0",
                         i, rsp0_valid, rsp0_Out, req1_ready, rsp1_valid);
            end
            tick();
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        #1;
        checks++;
        if (rsp0_valid !== 1'b0 || req1_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got=v0=%b r1rdy=%b exp=0 1", rsp0_valid, req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        tick();
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_Out !== 32'd2 || rsp1_flags !== 4'b0000) begin
            failures++;
            $display("FAIL bp_second got=v%b out=%h fl=%b exp=v1 out=2 fl=0000", rsp1_valid, rsp1_Out, rsp1_flags);
        end
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        idle_inputs();
        // req0 transaction completes, leaving prio favouring req1
        rsp0_ready = 1'b1;
        req0_valid = 1'b1; req0_A = 32'd2; req0_B = 32'd3; req0_Op = 4'd2;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        rsp0_ready = 1'b0;
        // req1 enters EXEC, then reset
        req1_valid = 1'b1; req1_A = 32'd7; req1_B = 32'd7; req1_Op = 4'd3;
        rsp1_ready = 1'b1;
        tick();
        req1_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || alu_A !== 32'd7) begin
            failures++;
            $display("FAIL rmid_exec got=busy=%b A=%h exp=1 7", busy, alu_A);
        end
        reset = 1'b1;
        req0_valid = 1'b1;
        tick();
        checks++;
        if ({rsp0_valid, rsp1_valid, busy, req0_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL rmid_ctrl got=%b exp=0000", {rsp0_valid, rsp1_valid, busy, req0_ready});
        end
        checks++;
        if (rsp1_Out !== '0 || rsp1_flags !== 4'h0 || alu_A !== '0 || alu_Op !== 4'hD) begin
            failures++;
            $display("FAIL rmid_data got=%h %b %h %h exp=0 0000 0 d", rsp1_Out, rsp1_flags, alu_A, alu_Op);
        end
        reset = 1'b0;
        req1_valid = 1'b1; req1_A = 32'd4; req1_B = 32'd4; req1_Op = 4'd2;
        req0_A = 32'd6; req0_B = 32'd6; req0_Op = 4'd2;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL rmid_prio got=%b%b exp=10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_Out !== 32'd12) begin
            failures++;
            $display("FAIL rmid_after got=v%b%b out=%h exp=v10 out=c", rsp0_valid, rsp1_valid, rsp0_Out);
        end
        rsp0_ready = 1'b1;
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_single_add();
        test_sub_flags();
        test_signed_cmp();
        test_flag_mask();
        test_arbitration();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
